datapath_pipe: RTL

- Parametrised successor of the single-cycle 8-bit datapath: register file, operand muxes, ALU and halt-on-zero check, generalised in data width and register count.
- Adds a two-stage issue/writeback pipeline with operand forwarding, registered status flags, a valid/ready issue handshake, and a sticky halt that can be cleared.
- Sits between the control sequencer, which issues one instruction per accepted cycle, and the top-level I/O, which monitors the last register.

---
 rtl/datapath_pipe_if.sv | 39 +++
 rtl/datapath_pipe.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/datapath_pipe_if.sv
// Issue/status bundle between the control sequencer (master) and datapath_pipe (slave).
// The sequencer drives instructions and halt_clr; the datapath returns ready, r_last, flags and halt.
interface datapath_pipe_if #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = $clog2(NUM_REGS)
);
   logic              in_valid;
   logic              in_ready;
   logic              write_en;
   logic              write_src_sel;
   logic              mux_a_sel;
   logic              mux_b_sel;
   logic              halt_chk;
   logic [DATA_W-1:0] ext_data;
   logic [ADDR_W-1:0] dest_addr;
   logic [ADDR_W-1:0] a_addr;
   logic [ADDR_W-1:0] b_addr;
   logic [3:0]        alu_op;
   logic              halt_clr;
   logic [DATA_W-1:0] r_last;
   logic              wb_valid;
   logic              flag_z;
   logic              flag_c;
   logic              flag_n;
   logic              halt;

   modport master (
      output in_valid, write_en, write_src_sel, mux_a_sel, mux_b_sel, halt_chk,
             ext_data, dest_addr, a_addr, b_addr, alu_op, halt_clr,
      input  in_ready, r_last, wb_valid, flag_z, flag_c, flag_n, halt
   );

   modport slave (
      input  in_valid, write_en, write_src_sel, mux_a_sel, mux_b_sel, halt_chk,
             ext_data, dest_addr, a_addr, b_addr, alu_op, halt_clr,
      output in_ready, r_last, wb_valid, flag_z, flag_c, flag_n, halt
   );
endinterface

// File: rtl/datapath_pipe.sv
// Two-stage register-file/ALU datapath with EX->issue forwarding, registered flags and sticky halt-on-zero.
// Result lands in the file two edges after issue; in_ready drops only while halt is set, never for hazards.
module datapath_pipe #(
   parameter  int DATA_W   = 8,
   parameter  int NUM_REGS = 16,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic            clk,
   input  logic            rst,
   datapath_pipe_if.slave  bus
);
   typedef logic [DATA_W-1:0] data_t;

   localparam logic [DATA_W:0] ONE_X = {{DATA_W{1'b0}}, 1'b1};

   data_t             regs_q [NUM_REGS];
   logic              ex_vld_q, ex_we_q, ex_wsrc_q;
   logic [3:0]        ex_op_q;
   logic [ADDR_W-1:0] ex_dest_q;
   data_t             ex_a_q, ex_b_q, ex_ext_q;
   logic              flag_z_q, flag_c_q, flag_n_q;
   logic              halt_q, halt_d;

   logic [DATA_W:0]   alu_ext;
   logic              alu_c;
   data_t             alu_res, ex_wdat;
   data_t             rd_a, rd_b, op_a_d, op_b_d;
   logic              accept;

   always_comb begin
      alu_ext = '0;
      alu_c   = 1'b0;
      case (ex_op_q)
         4'd0: begin
            alu_ext = {1'b0, ex_a_q} + {1'b0, ex_b_q};
            alu_c   = alu_ext[DATA_W];
         end
         4'd1: begin
            alu_ext = {1'b0, ex_a_q} - {1'b0, ex_b_q};
            alu_c   = alu_ext[DATA_W];
         end
         4'd2: alu_ext = {1'b0, ex_a_q & ex_b_q};
         4'd3: alu_ext = {1'b0, ex_a_q | ex_b_q};
         4'd4: alu_ext = {1'b0, ex_a_q ^ ex_b_q};
         4'd5: alu_ext = {1'b0, ~ex_a_q};
         4'd6: begin
            alu_ext = {ex_a_q, 1'b0};
            alu_c   = alu_ext[DATA_W];
         end
         4'd7: begin
            alu_ext = {2'b00, ex_a_q[DATA_W-1:1]};
            alu_c   = ex_a_q[0];
         end
         4'd8: alu_ext = {1'b0, ex_a_q};
         4'd9: alu_ext = {1'b0, ex_b_q};
         4'd10: begin
            alu_ext = {1'b0, ex_a_q} + ONE_X;
            alu_c   = alu_ext[DATA_W];
         end
         4'd11: begin
            // The wrap into bit DATA_W is exactly the borrow when A is zero.
            alu_ext = {1'b0, ex_a_q} - ONE_X;
            alu_c   = alu_ext[DATA_W];
         end
         default: begin
            alu_ext = '0;
            alu_c   = 1'b0;
         end
      endcase
   end

   assign alu_res = alu_ext[DATA_W-1:0];
   assign ex_wdat = ex_wsrc_q ? ex_ext_q : alu_res;

   always_comb begin
      rd_a = regs_q[bus.a_addr];
      rd_b = regs_q[bus.b_addr];
      if (ex_vld_q && ex_we_q && (ex_dest_q == bus.a_addr)) rd_a = ex_wdat;
      if (ex_vld_q && ex_we_q && (ex_dest_q == bus.b_addr)) rd_b = ex_wdat;
      op_a_d = bus.mux_a_sel ? bus.ext_data : rd_a;
      op_b_d = bus.mux_b_sel ? bus.ext_data : rd_b;
   end

   assign accept = bus.in_valid && !halt_q;

   always_comb begin
      halt_d = halt_q;
      if (accept && bus.halt_chk && (op_a_d == '0)) halt_d = 1'b1;
      if (bus.halt_clr) halt_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_vld_q  <= 1'b0;
         ex_we_q   <= 1'b0;
         ex_wsrc_q <= 1'b0;
         ex_op_q   <= '0;
         ex_dest_q <= '0;
         ex_a_q    <= '0;
         ex_b_q    <= '0;
         ex_ext_q  <= '0;
         flag_z_q  <= 1'b0;
         flag_c_q  <= 1'b0;
         flag_n_q  <= 1'b0;
         halt_q    <= 1'b0;
      end else begin
         ex_vld_q <= accept;
         if (accept) begin
            ex_we_q   <= bus.write_en;
            ex_wsrc_q <= bus.write_src_sel;
            ex_op_q   <= bus.alu_op;
            ex_dest_q <= bus.dest_addr;
            ex_a_q    <= op_a_d;
            ex_b_q    <= op_b_d;
            ex_ext_q  <= bus.ext_data;
         end
         if (ex_vld_q && !ex_wsrc_q) begin
            flag_z_q <= (alu_res == '0);
            flag_c_q <= alu_c;
            flag_n_q <= alu_res[DATA_W-1];
         end
         halt_q <= halt_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (ex_vld_q && ex_we_q) begin
         regs_q[ex_dest_q] <= ex_wdat;
      end
   end

   assign bus.in_ready = !halt_q;
   assign bus.r_last   = regs_q[NUM_REGS-1];
   assign bus.wb_valid = ex_vld_q;
   assign bus.flag_z   = flag_z_q;
   assign bus.flag_c   = flag_c_q;
   assign bus.flag_n   = flag_n_q;
   assign bus.halt     = halt_q;
endmodule
